// File: rtl/video_timing_pkg.sv
// Shared raster constants and helpers for the video timing generator.
// Defaults describe 640x480@60 at a 25.175 MHz pixel clock.
package video_timing_pkg;

  localparam int POS_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_LEAD     = 2;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [POS_W-1:0] pos_t;

  function automatic pos_t wrap_inc(input pos_t p, input pos_t last);
    return (p == last) ? '0 : p + pos_t'(1);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster position, sync and look-ahead strobes shared by the timing
// generator (master) and its consumers (slave).
interface video_timing_if;
  import video_timing_pkg::*;

  pos_t hPos;
  pos_t vPos;
  pos_t nextVPos;
  logic hsync;
  logic vsync;
  logic displayActive;
  logic hsyncStarting;
  logic nextFrameActive;
  logic lineStarting;
  logic lineEnding;
  logic frameStarting;

  modport master (
    output hPos, vPos, nextVPos, hsync, vsync, displayActive,
           hsyncStarting, nextFrameActive, lineStarting, lineEnding,
           frameStarting
  );

  modport slave (
    input hPos, vPos, nextVPos, hsync, vsync, displayActive,
          hsyncStarting, nextFrameActive, lineStarting, lineEnding,
          frameStarting
  );
endinterface

// File: rtl/video_timing_timing_axis.sv
// One raster axis: wrap counter with registered active-low sync. The next
// position is exported so the parent can register decodes without lag.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output pos_t pos,
  output pos_t pos_nxt,
  output logic sync_n,
  output logic active_nxt
);
  localparam int   TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam pos_t LAST    = pos_t'(TOTAL - 1);
  localparam pos_t ACT     = pos_t'(ACTIVE);
  localparam pos_t SYNC_LO = pos_t'(ACTIVE + FP);
  localparam pos_t SYNC_HI = pos_t'(ACTIVE + FP + SYNC);

  // Reset parks the counter on the last position so release lands on 0.
  always_comb begin
    pos_nxt = pos;
    if (rst)
      pos_nxt = LAST;
    else if (en)
      pos_nxt = wrap_inc(pos, LAST);
  end

  assign active_nxt = (pos_nxt < ACT);

  always_ff @(posedge clk) begin
    pos    <= pos_nxt;
    sync_n <= rst || !((pos_nxt >= SYNC_LO) && (pos_nxt < SYNC_HI));
  end
endmodule

// File: rtl/video_timing.sv
// Raster timing generator: H/V counters, active-low syncs and the
// look-ahead strobes the tile fetcher and pixel FIFO reader run from.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int LEAD     = DEF_LEAD
) (
  input  logic           clkPixel,
  input  logic           reset,
  video_timing_if.master vt
);
  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam pos_t H_LAST   = pos_t'(H_TOTAL - 1);
  localparam pos_t V_LAST   = pos_t'(V_TOTAL - 1);
  localparam pos_t V_ACT    = pos_t'(V_ACTIVE);
  localparam pos_t HS_START = pos_t'(H_ACTIVE + H_FP);
  localparam pos_t LS_COL   = pos_t'(H_TOTAL - LEAD);
  localparam pos_t LE_COL   = pos_t'(H_ACTIVE - LEAD);

  pos_t h_pos, h_nxt, v_pos, v_nxt, nv_nxt;
  logic h_sync_n, v_sync_n, h_act_nxt, v_act_nxt, v_en;

  assign v_en = (h_pos == H_LAST);

  timing_axis #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk(clkPixel), .rst(reset), .en(1'b1),
    .pos(h_pos), .pos_nxt(h_nxt), .sync_n(h_sync_n), .active_nxt(h_act_nxt)
  );

  timing_axis #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk(clkPixel), .rst(reset), .en(v_en),
    .pos(v_pos), .pos_nxt(v_nxt), .sync_n(v_sync_n), .active_nxt(v_act_nxt)
  );

  assign nv_nxt = wrap_inc(v_nxt, V_LAST);

  // Decodes use the next position so each strobe lines up with its hPos/vPos.
  always_ff @(posedge clkPixel) begin
    vt.nextVPos        <= nv_nxt;
    vt.nextFrameActive <= (nv_nxt < V_ACT);
    if (reset) begin
      vt.displayActive <= 1'b0;
      vt.hsyncStarting <= 1'b0;
      vt.lineStarting  <= 1'b0;
      vt.lineEnding    <= 1'b0;
      vt.frameStarting <= 1'b0;
    end else begin
      vt.displayActive <= h_act_nxt && v_act_nxt;
      vt.hsyncStarting <= (h_nxt == HS_START);
      vt.lineStarting  <= (h_nxt == LS_COL) && (nv_nxt < V_ACT);
      vt.lineEnding    <= (h_nxt == LE_COL) && v_act_nxt;
      vt.frameStarting <= (h_nxt == H_LAST) && (v_nxt == V_LAST);
    end
  end

  assign vt.hPos  = h_pos;
  assign vt.vPos  = v_pos;
  assign vt.hsync = h_sync_n;
  assign vt.vsync = v_sync_n;
endmodule

// File: doc/video_timing.md
# video_timing

Generates the raster timing for the display pipeline from the pixel clock: horizontal/vertical counters, active-low sync outputs, and the look-ahead strobes the background tile fetcher and its pixel FIFO reader run from (`hsyncStarting`, `nextVPos`, `nextFrameActive`, `lineStarting`, `lineEnding`). It sits at the head of the video path; every consumer of these strobes is timed from this block. The defaults give 640x480@60 (25.175 MHz pixel clock).

## Interface

Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `LEAD`, 2, pixel-read latency: cycles `lineStarting`/`lineEnding` precede the first/last-plus-one visible pixel

Ports:
- `clkPixel`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `hPos`  out  10  current column, 0..H_TOTAL-1
- `vPos`  out  10  current line, 0..V_TOTAL-1
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `displayActive`  out  1  current pixel visible
- `hsyncStarting`  out  1  1-cycle pulse, first cycle of hsync, every line
- `nextVPos`  out  10  line displayed after the current one (wraps to 0)
- `nextFrameActive`  out  1  `nextVPos < V_ACTIVE`
- `lineStarting`  out  1  1-cycle pulse LEAD cycles before pixel 0 of a visible line
- `lineEnding`  out  1  1-cycle pulse LEAD cycles before the end of a visible line
- `frameStarting`  out  1  1-cycle pulse on the last pixel of the frame

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Legal: H_TOTAL, V_TOTAL ≤ 1024; 1 ≤ LEAD ≤ H_BP; LEAD ≤ H_ACTIVE.
- Column order per line: active [0, H_ACTIVE), front porch, sync, back porch. Same ordering for lines.
- `hPos` increments every cycle; at H_TOTAL-1 wraps to 0 and `vPos` advances; `vPos` wraps V_TOTAL-1 → 0.
- `hsync` = 0 iff `hPos` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) (656..751). `vsync` = 0 iff `vPos` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) (490..491).
- `displayActive` = `hPos < H_ACTIVE && vPos < V_ACTIVE`.
- `hsyncStarting` = 1 iff `hPos == H_ACTIVE+H_FP`, on every line including vertical blanking.
- `nextVPos` = `vPos == V_TOTAL-1 ? 0 : vPos+1`; changes only in the cycle `vPos` changes.
- `lineStarting` = 1 iff `hPos == H_TOTAL-LEAD` and `nextFrameActive`.
- `lineEnding` = 1 iff `hPos == H_ACTIVE-LEAD` and `vPos < V_ACTIVE`.
- `frameStarting` = 1 iff `hPos == H_TOTAL-1 && vPos == V_TOTAL-1`.
- Exactly H_ACTIVE cycles separate `lineStarting` and the following `lineEnding`; exactly one of each per visible line.

## Timing

- All outputs are registered; every decoded output is valid in the same cycle as the `hPos`/`vPos` value it is defined against (decode from next-state, no extra lag).
- Reset (synchronous, any cycle, including mid-line): next edge loads `hPos`=H_TOTAL-1, `vPos`=V_TOTAL-1, `nextVPos`=0, `nextFrameActive`=1, `hsync`=`vsync`=1, `displayActive`=0, all pulses 0. State holds while `reset` is high; pulses stay 0 even though the reset position matches `frameStarting`.
- First edge after release: `hPos`=0, `vPos`=0, `displayActive`=1. Line 0 of that first frame receives no `hsyncStarting`/`lineStarting`; consumers show black for it. All later lines are fully strobed.
- Wrap coincidences: at (H_TOTAL-1, V_TOTAL-1) `frameStarting` fires; the next cycle `vPos`=0 and `nextVPos`=1 simultaneously.

## Structure

- Package `video_timing_pkg`: default 640x480 constants, derived H_TOTAL/V_TOTAL, position width (10).
- Sub-module `timing_axis`: parameterised wrap counter plus sync/active decode, instantiated once for H (enable = 1) and once for V (enable = H wrap).

## Test plan

- Free-run defaults one full frame after reset → exactly 800×525 cycles between `frameStarting` pulses; `hsync` low 96 cycles at `hPos` 656..751; `vsync` low for lines 490..491.
- Line 10 → `hsyncStarting` at `hPos`=656 with `nextVPos`=11, `nextFrameActive`=1; `lineStarting` at `hPos`=798; `lineEnding` at `hPos`=638 of line 11; 640 cycles apart.
- Lines 479/524 → `nextVPos`=480, `nextFrameActive`=0, no `lineStarting` during line 479; on line 524 `nextVPos`=0, `nextFrameActive`=1, `lineStarting` at `hPos`=798.
- Count over one frame → 480 `displayActive`-high lines of 640 cycles; 480 `lineStarting`, 480 `lineEnding`, 525 `hsyncStarting`.
- Assert `reset` at (hPos=300, vPos=200) for 3 cycles → outputs at reset values throughout, no pulses; first cycle after release (0,0), `displayActive`=1.
- Parameters H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=3, V=4/1/1/1, LEAD=3 → `lineStarting` at hPos 12, `lineEnding` at hPos 5, hsync low at 10..11, frame period 15×7=105 cycles.
